// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and widths for the ALU writeback stage
// State set depends on WB_TIMEOUT_EN (adds ST_ABORT).
package cpu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    CLS_LOAD   = 2'd0,
    CLS_STORE  = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_ALU    = 2'd3
  } cls_e;

`ifdef WB_TIMEOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_ALU = 3'd1,
    ST_MEM      = 3'd2,
    ST_WB       = 3'd3,
    ST_DONE     = 3'd4,
    ST_ABORT    = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_ALU = 3'd1,
    ST_MEM      = 3'd2,
    ST_WB       = 3'd3,
    ST_DONE     = 3'd4
  } state_e;
`endif

endpackage

// File: rtl/wb_pc_adder.sv
// rtl/wb_pc_adder.sv - combinational next-PC candidates
// Produces pc+1 and pc+1+sext(offset), both modulo 2^16.
module wb_pc_adder
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] i_pc,
  input  logic [5:0]        i_offset,
  output logic [DATA_W-1:0] o_pc_inc,
  output logic [DATA_W-1:0] o_pc_br
);

  logic [DATA_W-1:0] w_sext;

  assign w_sext   = {{(DATA_W-6){i_offset[5]}}, i_offset};
  assign o_pc_inc = i_pc + DATA_W'(1);
  assign o_pc_br  = o_pc_inc + w_sext;

endmodule

// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - post-execute stage: memory access, RF writeback or PC update
// Optional WB_TIMEOUT_EN adds a WAIT_ALU/MEM watchdog, ABORT state and sticky err.
module alu_writeback_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int RF_AW   = 3
) (
  input  logic                clk,
  input  logic                resetALU,
  input  logic                start,
  input  logic [1:0]          cls,
  input  logic [RF_AW-1:0]    rd_idx,
  input  logic [DATA_W-1:0]   pc,
  input  logic [5:0]          offset,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [DATA_W-1:0]   result,
  input  logic                executeComplete,
  input  logic                branchExecute,
  output logic                dm_req,
  output logic                dm_we,
  output logic [DATA_W-1:0]   dm_addr,
  output logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W-1:0]   dm_rdata,
  input  logic                dm_ack,
  output logic                rf_we,
  output logic [RF_AW-1:0]    rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [DATA_W-1:0]   pc_next,
  output logic                pc_load,
  output logic                busy,
  output logic                done,
  output logic                err
);

  if (TIMEOUT < 2) begin : g_timeout_range
    $error("alu_writeback_stage: TIMEOUT must be at least 2");
  end

  state_e             r_state;
  cls_e               r_cls;
  logic [RF_AW-1:0]   r_rd;
  logic [DATA_W-1:0]  r_pc;
  logic [5:0]         r_off;
  logic [DATA_W-1:0]  r_sdata;
  logic               r_lvl_prev;

  logic               w_lvl;
  logic               w_edge;
  logic [DATA_W-1:0]  w_pc_inc;
  logic [DATA_W-1:0]  w_pc_br;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   r_cnt;
  logic               w_expire;
  assign w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign err = 1'b0;
`endif

  // The previous level tracks continuously, so a level left high by the prior
  // instruction cannot produce an edge in WAIT_ALU.
  assign w_lvl  = executeComplete | branchExecute;
  assign w_edge = w_lvl & ~r_lvl_prev;

  wb_pc_adder u_pc_adder (
    .i_pc     (r_pc),
    .i_offset (r_off),
    .o_pc_inc (w_pc_inc),
    .o_pc_br  (w_pc_br)
  );

  always_ff @(posedge clk or posedge resetALU) begin
    if (resetALU) begin
      r_state    <= ST_IDLE;
      r_cls      <= CLS_LOAD;
      r_rd       <= '0;
      r_pc       <= '0;
      r_off      <= '0;
      r_sdata    <= '0;
      r_lvl_prev <= 1'b0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      pc_next    <= '0;
      pc_load    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef WB_TIMEOUT_EN
      r_cnt      <= '0;
      err        <= 1'b0;
`endif
    end else begin
      r_lvl_prev <= w_lvl;
      done       <= 1'b0;
      pc_load    <= 1'b0;
      rf_we      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cls   <= cls_e'(cls);
            r_rd    <= rd_idx;
            r_pc    <= pc;
            r_off   <= offset;
            r_sdata <= store_data;
            busy    <= 1'b1;
            r_state <= ST_WAIT_ALU;
`ifdef WB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        ST_WAIT_ALU: begin
          if (w_edge) begin
            case (r_cls)
              CLS_LOAD, CLS_STORE: begin
                dm_req   <= 1'b1;
                dm_we    <= (r_cls == CLS_STORE);
                dm_addr  <= result;
                dm_wdata <= (r_cls == CLS_STORE) ? r_sdata : '0;
                r_state  <= ST_MEM;
`ifdef WB_TIMEOUT_EN
                r_cnt    <= '0;
`endif
              end
              CLS_ALU: begin
                rf_we    <= (r_rd != '0);
                rf_waddr <= r_rd;
                rf_wdata <= result;
                r_state  <= ST_WB;
              end
              CLS_BRANCH: begin
                done     <= 1'b1;
                pc_load  <= 1'b1;
                pc_next  <= branchExecute ? w_pc_br : w_pc_inc;
                r_state  <= ST_DONE;
              end
            endcase
          end
`ifdef WB_TIMEOUT_EN
          else if (w_expire) begin
            done    <= 1'b1;
            err     <= 1'b1;
            r_state <= ST_ABORT;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
`endif
        end
        ST_MEM: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            if (r_cls == CLS_LOAD) begin
              rf_we    <= (r_rd != '0);
              rf_waddr <= r_rd;
              rf_wdata <= dm_rdata;
              r_state  <= ST_WB;
            end else begin
              done    <= 1'b1;
              pc_load <= 1'b1;
              pc_next <= w_pc_inc;
              r_state <= ST_DONE;
            end
          end
`ifdef WB_TIMEOUT_EN
          else if (w_expire) begin
            dm_req  <= 1'b0;
            dm_we   <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            r_state <= ST_ABORT;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
`endif
        end
        ST_WB: begin
          done    <= 1'b1;
          pc_load <= 1'b1;
          pc_next <= w_pc_inc;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
`ifdef WB_TIMEOUT_EN
        ST_ABORT: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
`endif
        default: begin
          busy    <= 1'b0;
          dm_req  <= 1'b0;
          dm_we   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb/tb_alu_writeback_stage.sv - directed self-checking bench for alu_writeback_stage
// The WB_TIMEOUT_EN block runs only when the macro is defined.
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        resetALU;
  logic        start;
  logic [1:0]  cls;
  logic [2:0]  rd_idx;
  logic [15:0] pc;
  logic [5:0]  offset;
  logic [15:0] store_data;
  logic [15:0] result;
  logic        executeComplete;
  logic        branchExecute;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_ack;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] pc_next;
  logic        pc_load;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_writeback_stage #(.TIMEOUT(8), .RF_AW(3)) dut (
    .clk             (clk),
    .resetALU        (resetALU),
    .start           (start),
    .cls             (cls),
    .rd_idx          (rd_idx),
    .pc              (pc),
    .offset          (offset),
    .store_data      (store_data),
    .result          (result),
    .executeComplete (executeComplete),
    .branchExecute   (branchExecute),
    .dm_req          (dm_req),
    .dm_we           (dm_we),
    .dm_addr         (dm_addr),
    .dm_wdata        (dm_wdata),
    .dm_rdata        (dm_rdata),
    .dm_ack          (dm_ack),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .pc_next         (pc_next),
    .pc_load         (pc_load),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic [2:0] rd, input logic [15:0] p,
                       input logic [5:0] off, input logic [15:0] sd);
    start = 1'b1; cls = c; rd_idx = rd; pc = p; offset = off; store_data = sd;
    tick();
    start = 1'b0; store_data = 16'h0;
  endtask

  initial begin
    resetALU = 1'b1; start = 1'b0; cls = 2'd0; rd_idx = 3'd0; pc = 16'h0;
    offset = 6'd0; store_data = 16'h0; result = 16'h0; executeComplete = 1'b0;
    branchExecute = 1'b0; dm_rdata = 16'h0; dm_ack = 1'b0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outs", {26'd0, dm_req, dm_we, rf_we, pc_load, done, err}, 32'd0);
    check("rst_pc_next", {16'd0, pc_next}, 32'd0);
    resetALU = 1'b0;
    tick();

    // ALU add to r2
    issue(2'd3, 3'd2, 16'h0100, 6'd0, 16'h0);
    check("alu_busy", {31'd0, busy}, 32'd1);
    result = 16'h0007; executeComplete = 1'b1;
    check("alu_no_early_we", {31'd0, rf_we}, 32'd0);
    tick();
    check("alu_rf_we", {31'd0, rf_we}, 32'd1);
    check("alu_rf_waddr", {29'd0, rf_waddr}, 32'd2);
    check("alu_rf_wdata", {16'd0, rf_wdata}, 32'h0007);
    check("alu_done_early", {31'd0, done}, 32'd0);
    tick();
    check("alu_done", {30'd0, done, pc_load}, 32'd3);
    check("alu_pc_next", {16'd0, pc_next}, 32'h0101);
    check("alu_we_cleared", {31'd0, rf_we}, 32'd0);
    tick();
    check("alu_idle", {30'd0, busy, done}, 32'd0);

    // executeComplete still high at issue: must wait for a fresh edge
    issue(2'd3, 3'd5, 16'hFFFF, 6'd0, 16'h0);
    result = 16'h0055;
    tick(); tick(); tick();
    check("stale_no_we", {31'd0, rf_we}, 32'd0);
    check("stale_busy_nodone", {30'd0, busy, done}, 32'd2);
    executeComplete = 1'b0;
    tick();
    executeComplete = 1'b1;
    tick();
    check("stale_rf_we", {31'd0, rf_we}, 32'd1);
    check("stale_rf", {13'd0, rf_waddr, rf_wdata}, {13'd0, 3'd5, 16'h0055});
    tick();
    check("stale_done", {31'd0, done}, 32'd1);
    check("wrap_pc_next", {16'd0, pc_next}, 32'h0000);
    tick();
    executeComplete = 1'b0;

    // LOAD to r3, ack in third MEM cycle
    issue(2'd0, 3'd3, 16'h0200, 6'd0, 16'h0);
    executeComplete = 1'b1; result = 16'h0010;
    tick();
    executeComplete = 1'b0; result = 16'hAAAA;
    check("ld_req", {30'd0, dm_req, dm_we}, 32'd2);
    check("ld_addr1", {16'd0, dm_addr}, 32'h0010);
    tick();
    check("ld_addr2", {16'd0, dm_addr}, 32'h0010);
    tick();
    check("ld_addr3", {15'd0, dm_req, dm_addr}, {15'd0, 1'b1, 16'h0010});
    dm_ack = 1'b1; dm_rdata = 16'hBEEF;
    tick();
    dm_ack = 1'b0; dm_rdata = 16'h0;
    check("ld_req_drop", {31'd0, dm_req}, 32'd0);
    check("ld_rf", {12'd0, rf_we, rf_waddr, rf_wdata}, {12'd0, 1'b1, 3'd3, 16'hBEEF});
    tick();
    check("ld_done", {30'd0, done, pc_load}, 32'd3);
    check("ld_pc_next", {16'd0, pc_next}, 32'h0201);
    tick();

    // Taken branch with negative offset
    issue(2'd2, 3'd4, 16'h0020, 6'b111110, 16'h0);
    branchExecute = 1'b1;
    tick();
    check("br_done", {29'd0, done, pc_load, rf_we}, 32'd6);
    check("br_pc_next", {16'd0, pc_next}, 32'h001F);
    tick();
    branchExecute = 1'b0;
    check("br_idle", {31'd0, busy}, 32'd0);

    // Branch class completed without branchExecute: not taken
    issue(2'd2, 3'd0, 16'h0030, 6'd5, 16'h0);
    executeComplete = 1'b1;
    tick();
    executeComplete = 1'b0;
    check("bnt_pc_next", {15'd0, pc_load, pc_next}, {15'd0, 1'b1, 16'h0031});
    tick();

    // STORE with rd 0; stray ack while in WAIT_ALU must be ignored
    issue(2'd1, 3'd0, 16'h0300, 6'd0, 16'h1234);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    check("st_ack_ignored", {30'd0, busy, dm_req}, 32'd2);
    executeComplete = 1'b1; result = 16'h0040;
    tick();
    executeComplete = 1'b0;
    check("st_req_we", {30'd0, dm_req, dm_we}, 32'd3);
    check("st_wdata", {dm_addr, dm_wdata}, {16'h0040, 16'h1234});
    tick();
    check("st_hold", {14'd0, dm_req, dm_we, dm_wdata}, {14'd0, 2'b11, 16'h1234});
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    check("st_done", {27'd0, done, pc_load, dm_req, dm_we, rf_we}, 32'h18);
    check("st_pc_next", {16'd0, pc_next}, 32'h0301);
    tick();

    // branchExecute on ALU class acts as completion; rd 0 write suppressed
    issue(2'd3, 3'd0, 16'h0400, 6'd3, 16'h0);
    branchExecute = 1'b1; result = 16'h0099;
    tick();
    branchExecute = 1'b0;
    check("r0_suppressed", {31'd0, rf_we}, 32'd0);
    tick();
    check("r0_done_pc", {15'd0, done, pc_next}, {15'd0, 1'b1, 16'h0401});
    tick();

    // Asynchronous reset in MEM
    issue(2'd0, 3'd1, 16'h0500, 6'd0, 16'h0);
    executeComplete = 1'b1; result = 16'h0077;
    tick();
    executeComplete = 1'b0;
    check("rst_mem_req", {31'd0, dm_req}, 32'd1);
    #2 resetALU = 1'b1;
    #1;
    check("rst_async_drop", {29'd0, dm_req, busy, rf_we}, 32'd0);
    tick();
    resetALU = 1'b0;
    tick();
    check("rst_err", {31'd0, err}, 32'd0);

`ifdef WB_TIMEOUT_EN
    issue(2'd3, 3'd1, 16'h0600, 6'd0, 16'h0);
    repeat (7) tick();
    check("to_not_yet", {31'd0, done}, 32'd0);
    tick();
    check("to_abort", {28'd0, done, err, pc_load, rf_we}, 32'hC);
    tick();
    check("to_sticky", {30'd0, err, busy}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
